// File: rtl/form_and_function_cpu.sv
// Single-cycle 8-bit register CPU: four registers, carry flag, output latch with
// pad enable, and a 7-segment hex digit display.
module form_and_function_cpu (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0, OP_MOV  = 4'h1, OP_ADD  = 4'h2, OP_SUB  = 4'h3,
        OP_AND  = 4'h4, OP_OR   = 4'h5, OP_XOR  = 4'h6, OP_NOT  = 4'h7,
        OP_SHL  = 4'h8, OP_SHR  = 4'h9, OP_LDI  = 4'hA, OP_OUT  = 4'hB,
        OP_INC  = 4'hC, OP_DEC  = 4'hD, OP_DISP = 4'hE, OP_SWAP = 4'hF
    } opcode_t;

    logic [7:0] regs_reg [4];
    logic       carry_reg, carry_next;
    logic [3:0] disp_reg, disp_next;
    logic [7:0] out_reg, out_next;
    logic       oe_reg, oe_next;

    opcode_t    op;
    logic [1:0] rd, rs;
    logic [7:0] a, b, result;
    logic       reg_we;
    logic [8:0] sum9;
    logic [6:0] seg;

    assign op = opcode_t'(ui_in[7:4]);
    assign rd = ui_in[3:2];
    assign rs = ui_in[1:0];
    // Both operands are read before the write, so rd==rs sees the old value.
    assign a  = regs_reg[rd];
    assign b  = regs_reg[rs];

    always_comb begin
        result     = a;
        reg_we     = 1'b0;
        carry_next = carry_reg;
        disp_next  = disp_reg;
        out_next   = out_reg;
        oe_next    = oe_reg;
        sum9       = {1'b0, a} + {1'b0, b};
        case (op)
            OP_NOP:  ;
            OP_MOV:  begin result = b; reg_we = 1'b1; end
            OP_ADD:  begin result = sum9[7:0]; carry_next = sum9[8]; reg_we = 1'b1; end
            OP_SUB:  begin result = a - b; carry_next = (a < b); reg_we = 1'b1; end
            OP_AND:  begin result = a & b; carry_next = 1'b0; reg_we = 1'b1; end
            OP_OR:   begin result = a | b; carry_next = 1'b0; reg_we = 1'b1; end
            OP_XOR:  begin result = a ^ b; carry_next = 1'b0; reg_we = 1'b1; end
            OP_NOT:  begin result = ~a; carry_next = 1'b0; reg_we = 1'b1; end
            OP_SHL:  begin result = {a[6:0], 1'b0}; carry_next = a[7]; reg_we = 1'b1; end
            OP_SHR:  begin result = {1'b0, a[7:1]}; carry_next = a[0]; reg_we = 1'b1; end
            OP_LDI:  begin result = uio_in; oe_next = 1'b0; reg_we = 1'b1; end
            OP_OUT:  begin out_next = a; oe_next = 1'b1; end
            OP_INC:  begin result = a + 8'd1; carry_next = (a == 8'hFF); reg_we = 1'b1; end
            OP_DEC:  begin result = a - 8'd1; carry_next = (a == 8'h00); reg_we = 1'b1; end
            OP_DISP: disp_next = a[3:0];
            OP_SWAP: begin result = {a[3:0], a[7:4]}; reg_we = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 4; i++) regs_reg[i] <= 8'h00;
            carry_reg <= 1'b0;
            disp_reg  <= 4'h0;
            out_reg   <= 8'h00;
            oe_reg    <= 1'b0;
        end else if (ena) begin
            if (reg_we) regs_reg[rd] <= result;
            carry_reg <= carry_next;
            disp_reg  <= disp_next;
            out_reg   <= out_next;
            oe_reg    <= oe_next;
        end
    end

    always_comb begin
        seg = 7'h00;
        case (disp_reg)
            4'h0: seg = 7'h3F; 4'h1: seg = 7'h06; 4'h2: seg = 7'h5B; 4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66; 4'h5: seg = 7'h6D; 4'h6: seg = 7'h7D; 4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F; 4'h9: seg = 7'h6F; 4'hA: seg = 7'h77; 4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39; 4'hD: seg = 7'h5E; 4'hE: seg = 7'h79; 4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
    end

    assign uo_out  = {carry_reg, seg};
    assign uio_out = out_reg;
    assign uio_oe  = {8{oe_reg}};

endmodule

// File: tb/tb_form_and_function_cpu.sv
// Directed plan steps plus randomized instruction stream, every step compared
// against an arithmetic reference model of the CPU.
module tb_form_and_function_cpu;

    logic       clk = 1'b0;
    logic       rst_n, ena;
    logic [7:0] ui_in, uio_in;
    logic [7:0] uo_out, uio_out, uio_oe;

    int checks = 0;
    int errors = 0;

    int m_r [4];
    int m_c, m_d, m_o, m_oe;
    int seg_tab [16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                         'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};

    form_and_function_cpu dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    function automatic void model_apply(input int ins, input int imm);
        int op, rd, rs, x, y, s;
        op = ins / 16; rd = (ins / 4) % 4; rs = ins % 4;
        x = m_r[rd]; y = m_r[rs];
        case (op)
            1:  m_r[rd] = y;
            2:  begin s = x + y; m_c = (s > 255); m_r[rd] = s % 256; end
            3:  begin m_c = (x < y); m_r[rd] = (x - y + 256) % 256; end
            4:  begin m_r[rd] = x & y; m_c = 0; end
            5:  begin m_r[rd] = x | y; m_c = 0; end
            6:  begin m_r[rd] = x ^ y; m_c = 0; end
            7:  begin m_r[rd] = 255 - x; m_c = 0; end
            8:  begin m_c = (x >= 128); m_r[rd] = (x * 2) % 256; end
            9:  begin m_c = x % 2; m_r[rd] = x / 2; end
            10: begin m_r[rd] = imm; m_oe = 0; end
            11: begin m_o = x; m_oe = 1; end
            12: begin m_c = (x == 255); m_r[rd] = (x + 1) % 256; end
            13: begin m_c = (x == 0); m_r[rd] = (x + 255) % 256; end
            14: m_d = x % 16;
            15: m_r[rd] = (x % 16) * 16 + x / 16;
            default: ;
        endcase
    endfunction

    // Apply one edge's worth of inputs, advance the model, compare all outputs.
    task automatic step(input logic [7:0] ins, input logic [7:0] imm,
                        input logic en, input logic rst);
        @(negedge clk);
        ui_in = ins; uio_in = imm; ena = en; rst_n = rst;
        @(posedge clk);
        #1;
        if (rst) begin
            m_r = '{0, 0, 0, 0}; m_c = 0; m_d = 0; m_o = 0; m_oe = 0;
        end else if (en) begin
            model_apply(int'(ins), int'(imm));
        end
        check8($sformatf("uo_out ins=%02h", ins), uo_out, 8'(m_c * 128 + seg_tab[m_d]));
        check8($sformatf("uio_out ins=%02h", ins), uio_out, 8'(m_o));
        check8($sformatf("uio_oe ins=%02h", ins), uio_oe, m_oe ? 8'hFF : 8'h00);
        $display("step ins=%02h imm=%02h ena=%0b rst=%0b -> uo=%02h uio_out=%02h oe=%02h",
                 ins, imm, en, rst, uo_out, uio_out, uio_oe);
    endtask

    initial begin
        logic [7:0] held_uo, held_out, held_oe;
        ui_in = 8'h00; uio_in = 8'h00; ena = 1'b0; rst_n = 1'b1;

        // Reset for two cycles with random instructions present.
        step(8'($urandom), 8'($urandom), 1'b1, 1'b1);
        step(8'($urandom), 8'($urandom), 1'b1, 1'b1);
        check8("reset uo_out", uo_out, 8'h3F);
        check8("reset uio_out", uio_out, 8'h00);
        check8("reset uio_oe", uio_oe, 8'h00);

        // Add and output.
        step(8'hA0, 8'h25, 1'b1, 1'b0);
        step(8'hA4, 8'h13, 1'b1, 1'b0);
        step(8'h21, 8'h00, 1'b1, 1'b0);
        step(8'hB0, 8'h00, 1'b1, 1'b0);
        check8("addout uio_out", uio_out, 8'h38);
        check8("addout uio_oe", uio_oe, 8'hFF);
        check8("addout carry", {7'd0, uo_out[7]}, 8'h00);

        // Carry out plus display.
        step(8'hA0, 8'hFF, 1'b1, 1'b0);
        step(8'hA4, 8'h01, 1'b1, 1'b0);
        step(8'h21, 8'h00, 1'b1, 1'b0);
        step(8'hE0, 8'h00, 1'b1, 1'b0);
        check8("carry disp", uo_out, 8'hBF);

        // Borrow, then swap.
        step(8'hA0, 8'h03, 1'b1, 1'b0);
        step(8'hA4, 8'h05, 1'b1, 1'b0);
        step(8'h31, 8'h00, 1'b1, 1'b0);
        step(8'hE0, 8'h00, 1'b1, 1'b0);
        check8("borrow disp", uo_out, 8'hF9);
        step(8'hF0, 8'h00, 1'b1, 1'b0);
        step(8'hE0, 8'h00, 1'b1, 1'b0);
        check8("swap disp", uo_out, 8'hF1);

        // Enable gating: five disabled INCs, then one enabled INC.
        held_uo = uo_out; held_out = uio_out; held_oe = uio_oe;
        for (int i = 0; i < 5; i++) step(8'hC0, 8'h00, 1'b0, 1'b0);
        check8("ena0 uo_out", uo_out, held_uo);
        check8("ena0 uio_out", uio_out, held_out);
        check8("ena0 uio_oe", uio_oe, held_oe);
        step(8'hC0, 8'h00, 1'b1, 1'b0);
        step(8'hB0, 8'h00, 1'b1, 1'b0);
        check8("inc once", uio_out, 8'hF0);

        // Mid-run reset discards the ADD on that edge.
        step(8'h21, 8'h00, 1'b1, 1'b1);
        check8("midrst uo_out", uo_out, 8'h3F);
        check8("midrst uio_out", uio_out, 8'h00);
        check8("midrst uio_oe", uio_oe, 8'h00);
        step(8'hB0, 8'h00, 1'b1, 1'b0);
        check8("midrst out r0", uio_out, 8'h00);

        // Random instruction stream with sporadic enable drops and resets.
        for (int i = 0; i < 400; i++) begin
            step(8'($urandom), 8'($urandom),
                 ($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/form_and_function_cpu.md
# form_and_function_cpu

Minimal 8-bit register CPU occupying one user tile. Each enabled clock it executes one instruction byte presented on `ui_in`, operating on four 8-bit registers and a carry flag. Immediate data enters on `uio_in` and results leave on `uio_out`. A hex digit is shown on a 7-segment display driven from `uo_out`.

## Interface
- No parameters.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  reset; synchronous, active-high (asserted when 1); has priority over everything else.
- `ena`  input  1  execute enable; when 0 all state holds.
- `ui_in`  input  8  instruction: [7:4] opcode, [3:2] rd, [1:0] rs.
- `uio_in`  input  8  immediate data for LDI.
- `uo_out`  output  8  [6:0] 7-segment pattern of the display digit (bit0=a … bit6=g, active-high); [7] carry flag C.
- `uio_out`  output  8  output latch written by OUT.
- `uio_oe`  output  8  bidirectional pad enable: 0x00 = input, 0xFF = output.

## Operation
- State:
  - registers R0–R3 (8b)
  - carry C
  - display nibble D (4b)
  - output latch O (8b)
  - OE bit (drives all 8 `uio_oe` bits)
- Opcode table (8-bit arithmetic, results mod 256; "C kept" means C unchanged):
  - 0 NOP: no change.
  - 1 MOV: rd←rs; C kept.
  - 2 ADD: rd←rd+rs; C=carry out of bit 7.
  - 3 SUB: rd←rd−rs; C=1 iff rd<rs (unsigned borrow).
  - 4 AND, 5 OR, 6 XOR: rd←rd op rs; C←0.
  - 7 NOT: rd←~rd; C←0.
  - 8 SHL: rd←rd<<1; C=old bit7.
  - 9 SHR: rd←rd>>1, logical; C=old bit0.
  - A LDI: rd←uio_in; OE←0; C kept.
  - B OUT: O←rd; OE←1; C kept.
  - C INC: rd←rd+1; C=1 iff old rd=0xFF.
  - D DEC: rd←rd−1; C=1 iff old rd=0x00.
  - E DISP: D←rd[3:0]; C kept.
  - F SWAP: rd←{rd[3:0],rd[7:4]}; C kept.
- When rd==rs, the source operand is the old value of that register (e.g. ADD R0,R0 doubles R0).
- Segment map for D = 0…F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- `uo_out` = {C, seg(D)}.
- `uio_out` = O.
- `uio_oe` = {8{OE}}.
- All outputs are combinational from registered state only. No combinational path from `ui_in`/`uio_in` to any output.

## Timing
- Single-cycle execution: an instruction sampled on rising edge N with `ena`=1 and reset low has its effects visible on outputs after edge N.
- Reset (`rst_n`=1 at an edge) clears everything:
  - R0–R3=0, C=0, D=0, O=0, OE=0.
  - Outputs: `uo_out`=0x3F, `uio_out`=0x00, `uio_oe`=0x00.
- Reset asserted mid-sequence discards the instruction on that edge. Execution resumes with the first edge where reset is low and `ena`=1.
- `ena`=0: instruction ignored, all state and outputs hold. `ena` toggling never corrupts state.
- No multi-cycle operations, no handshake. A new instruction may be applied every cycle.
- LDI samples `uio_in` on the same edge as the instruction. The bench must drive `uio_in` while `uio_oe`=0x00.

## Test plan
- Reset: hold `rst_n`=1 for 2 cycles with random `ui_in` → `uo_out`=0x3F, `uio_out`=0x00, `uio_oe`=0x00.
- Add/out: sequence below → `uio_out`=0x38, `uio_oe`=0xFF, `uo_out[7]`=0.
  - LDI R0 (0xA0, `uio_in`=0x25)
  - LDI R1 (0xA4, `uio_in`=0x13)
  - ADD R0,R1 (0x21)
  - OUT R0 (0xB0)
- Carry + display: LDI R0=0xFF, LDI R1=0x01, ADD 0x21, DISP R0 (0xE0) → `uo_out`=0xBF (C=1, digit 0).
- Borrow/swap: sequence below → `uo_out`=0xF9 after DISP (digit E, C=1); after SWAP 0xF0, DISP → 0xF1 (digit F, C still 1).
  - LDI R0=0x03, LDI R1=0x05
  - SUB R0,R1 (0x31) → R0=0xFE, C=1
  - DISP R0
- Enable gating: with `ena`=0, apply INC R0 (0xC0) for 5 cycles → outputs unchanged. With `ena`=1, one cycle, then OUT → R0 incremented exactly once.
- Mid-run reset: after OUT leaves `uio_oe`=0xFF, assert `rst_n`=1 for one edge while `ui_in`=0x21 → all outputs return to reset values, and a following OUT R0 gives `uio_out`=0x00.
